// File: rtl/dpb_pkg.sv
// Shared DPB rank header layout, address widths and read-master states.
// Used by both the write path and the read master.
package dpb_pkg;

    localparam int LAST_BIT   = 127;
    localparam int RANK_MSB   = 119;
    localparam int RANK_LSB   = 112;
    localparam int CNT_MSB    = 110;
    localparam int CNT_LSB    = 104;
    localparam int BCNT_MSB   = 101;
    localparam int BCNT_LSB   = 96;

    localparam int DPB_ADDR_W = 11;
    localparam int RANK_W     = 4;
    localparam int WORD_W     = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CHK,
        ST_FILL,
        ST_STREAM
    } rd_state_t;

    function automatic logic hdr_bad(
        input logic [127:0]       h,
        input logic [WORD_W-1:0]  max_cnt
    );
        logic [WORD_W-1:0] cnt;
        cnt = h[CNT_MSB:CNT_LSB];
        return (|h[126:120]) | h[111] | (|h[103:102]) |
               (|h[95:0]) | (cnt == '0) | (cnt > max_cnt) |
               (h[BCNT_MSB:BCNT_LSB] > 6'd15);
    endfunction

    // A zero byte count means the final word is full.
    function automatic logic [10:0] pkt_len(
        input logic [6:0] cnt,
        input logic [5:0] bcnt
    );
        logic [10:0] tail;
        tail = (bcnt == 6'd0) ? 11'd16 : {5'd0, bcnt};
        return (({4'd0, cnt} - 11'd1) << 4) + tail;
    endfunction

endpackage

// File: rtl/dpb_word_serializer.sv
// 128-bit word to byte stream, MSB byte first, with a one-word
// prefetch hold register and total-byte-count termination.
module dpb_word_serializer (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [10:0]  i_len,
    input  logic         i_wr,
    input  logic [127:0] i_data,
    input  logic         i_ready,
    output logic         o_load,
    output logic         o_fin,
    output logic         o_valid,
    output logic         o_sof,
    output logic         o_last,
    output logic [7:0]   o_data
);

    logic [127:0] r_shift;
    logic [127:0] r_hold;
    logic         r_valid;
    logic         r_armed;
    logic         r_sof;
    logic [3:0]   r_bidx;
    logic [10:0]  r_rem;

    logic w_hs;
    logic w_last;
    logic w_word_end;
    logic w_first;

    assign w_hs       = r_valid & i_ready;
    assign w_last     = (r_rem == 11'd1);
    assign w_word_end = w_hs & ~w_last & (r_bidx == 4'd15);
    assign w_first    = r_armed & i_wr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift <= '0;
            r_hold  <= '0;
            r_valid <= 1'b0;
            r_armed <= 1'b0;
            r_sof   <= 1'b0;
            r_bidx  <= '0;
            r_rem   <= '0;
        end else begin
            if (i_start) begin
                r_rem   <= i_len;
                r_armed <= 1'b1;
                r_sof   <= 1'b1;
            end
            // First word goes straight to the shifter, later ones wait in hold.
            if (w_first) begin
                r_shift <= i_data;
                r_valid <= 1'b1;
                r_armed <= 1'b0;
                r_bidx  <= '0;
            end else if (i_wr) begin
                r_hold <= i_data;
            end
            if (w_hs) begin
                r_rem  <= r_rem - 11'd1;
                r_sof  <= 1'b0;
                r_bidx <= r_bidx + 4'd1;
                r_shift <= {r_shift[119:0], 8'h00};
                if (w_word_end)
                    r_shift <= r_hold;
                if (w_last)
                    r_valid <= 1'b0;
            end
        end
    end

    assign o_load  = w_first | w_word_end;
    assign o_fin   = w_hs & w_last;
    assign o_valid = r_valid;
    assign o_sof   = r_valid & r_sof;
    assign o_last  = r_valid & w_last;
    assign o_data  = r_shift[127:120];

endmodule

// File: rtl/dpb_master_rd.sv
// DPB port-B read master: fetches a rank header, validates it and
// streams the payload words as bytes to the UDP packer.
module dpb_master_rd
    import dpb_pkg::*;
#(
    parameter logic [6:0] UDP_FRAME_MAX_SIZE_128 = 7'd91,
    parameter int         RD_LATENCY             = 2
) (
    input  logic         i_pclk,
    input  logic         i_rst,
    input  logic         i_rd_req,
    input  logic [3:0]   i_rd_buf_rank,
    output logic         o_rd_busy,
    output logic         o_rd_done,
    output logic         o_rd_error,
    output logic         o_dpb_rd_b_clk,
    output logic         o_dpb_rd_b_ce,
    output logic         o_dpb_rd_b_oce,
    output logic         o_dpb_rd_b_rst,
    output logic         o_dpb_rd_b_wr_en,
    output logic [10:0]  o_dpb_rd_b_addr,
    input  logic [127:0] i_dpb_rd_b_rd_data,
    output logic         o_hdr_valid,
    output logic         o_hdr_last,
    output logic [7:0]   o_hdr_udp_rank,
    output logic [6:0]   o_hdr_word_cnt,
    output logic [5:0]   o_hdr_byte_cnt,
    output logic [10:0]  o_pkt_len,
    output logic [7:0]   o_byte_data,
    output logic         o_byte_valid,
    input  logic         i_byte_ready,
    output logic         o_byte_sof,
    output logic         o_byte_last
);

    rd_state_t r_state;
    rd_state_t w_nxt;

    logic [RANK_W-1:0]     r_rank;
    logic [WORD_W-1:0]     r_word;
    logic [DPB_ADDR_W-1:0] r_addr;
    logic [127:0]          r_hdr;
    logic                  r_busy;
    logic                  r_err;
    logic                  r_hvld;
    logic                  r_done;
    logic [RD_LATENCY:0]   r_pend;

    logic        w_acc;
    logic        w_cap;
    logic        w_ok;
    logic        w_herr;
    logic        w_issue;
    logic        w_rvld;
    logic        w_ser_wr;
    logic        w_load;
    logic        w_fin;
    logic        w_more;
    logic        w_bad;
    logic [6:0]  w_cnt;
    logic [10:0] w_len;

    assign w_cnt    = r_hdr[CNT_MSB:CNT_LSB];
    assign w_len    = pkt_len(w_cnt, r_hdr[BCNT_MSB:BCNT_LSB]);
    assign w_bad    = hdr_bad(r_hdr, UDP_FRAME_MAX_SIZE_128);
    assign w_rvld   = r_pend[RD_LATENCY];
    assign w_more   = (r_word < w_cnt);
    assign w_ser_wr = w_rvld &
                      ((r_state == ST_FILL) | (r_state == ST_STREAM));

    always_comb begin
        w_nxt   = r_state;
        w_acc   = 1'b0;
        w_cap   = 1'b0;
        w_ok    = 1'b0;
        w_herr  = 1'b0;
        w_issue = 1'b0;
        unique case (r_state)
            ST_IDLE: if (i_rd_req) begin
                w_nxt   = ST_HDR;
                w_acc   = 1'b1;
                w_issue = 1'b1;
            end
            ST_HDR: if (w_rvld) begin
                w_nxt = ST_CHK;
                w_cap = 1'b1;
            end
            ST_CHK: if (w_bad) begin
                w_nxt  = ST_IDLE;
                w_herr = 1'b1;
            end else begin
                w_nxt   = ST_FILL;
                w_ok    = 1'b1;
                w_issue = 1'b1;
            end
            ST_FILL: if (w_load) w_nxt = ST_STREAM;
            ST_STREAM: if (w_fin) w_nxt = ST_IDLE;
            default: w_nxt = ST_IDLE;
        endcase
        // Each word load prefetches the next, stopping at the header count.
        if (w_load && w_more)
            w_issue = 1'b1;
    end

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_rank  <= '0;
            r_word  <= '0;
            r_addr  <= '0;
            r_hdr   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_hvld  <= 1'b0;
            r_done  <= 1'b0;
            r_pend  <= '0;
        end else begin
            r_state <= w_nxt;
            r_pend  <= {r_pend[RD_LATENCY-1:0], w_issue};
            r_err   <= w_herr;
            r_hvld  <= w_ok;
            r_done  <= w_fin;
            if (w_acc) begin
                r_rank <= i_rd_buf_rank;
                r_addr <= {i_rd_buf_rank, 7'd0};
                r_busy <= 1'b1;
            end
            if (w_cap)
                r_hdr <= i_dpb_rd_b_rd_data;
            if (w_ok) begin
                r_word <= 7'd1;
                r_addr <= {r_rank, 7'd1};
            end
            if (w_load && w_more) begin
                r_word <= r_word + 7'd1;
                r_addr <= {r_rank, r_word + 7'd1};
            end
            if (w_herr || w_fin)
                r_busy <= 1'b0;
        end
    end

    dpb_word_serializer u_ser (
        .i_clk   (i_pclk),
        .i_rst   (i_rst),
        .i_start (w_ok),
        .i_len   (w_len),
        .i_wr    (w_ser_wr),
        .i_data  (i_dpb_rd_b_rd_data),
        .i_ready (i_byte_ready),
        .o_load  (w_load),
        .o_fin   (w_fin),
        .o_valid (o_byte_valid),
        .o_sof   (o_byte_sof),
        .o_last  (o_byte_last),
        .o_data  (o_byte_data)
    );

    assign o_rd_busy        = r_busy;
    assign o_rd_done        = r_done;
    assign o_rd_error       = r_err;
    assign o_dpb_rd_b_clk   = i_pclk;
    assign o_dpb_rd_b_ce    = 1'b1;
    assign o_dpb_rd_b_oce   = 1'b1;
    assign o_dpb_rd_b_rst   = i_rst;
    assign o_dpb_rd_b_wr_en = 1'b0;
    assign o_dpb_rd_b_addr  = r_addr;
    assign o_hdr_valid      = r_hvld;
    assign o_hdr_last       = r_hdr[LAST_BIT];
    assign o_hdr_udp_rank   = r_hdr[RANK_MSB:RANK_LSB];
    assign o_hdr_word_cnt   = w_cnt;
    assign o_hdr_byte_cnt   = r_hdr[BCNT_MSB:BCNT_LSB];
    assign o_pkt_len        = w_len;

endmodule

// File: tb/tb_dpb_master_rd.sv
// Scoreboard bench for dpb_master_rd with a latency-modelled DPB
// memory and a byte-level reference model of the packet payload.
module tb_dpb_master_rd;

    localparam int LAT = 2;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       l;
    } byte_t;

    typedef struct {
        logic        lst;
        logic [7:0]  ur;
        logic [6:0]  cnt;
        logic [5:0]  bcnt;
        logic [10:0] len;
    } hdr_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [3:0]   rank_in;
    logic         busy, done, err;
    logic         b_clk, b_ce, b_oce, b_rst, b_wr;
    logic [10:0]  addr;
    logic [127:0] rd_data;
    logic         hvld, hlast;
    logic [7:0]   hrank;
    logic [6:0]   hcnt;
    logic [5:0]   hbcnt;
    logic [10:0]  plen;
    logic [7:0]   bdata;
    logic         bvalid, bsof, blast;
    logic         ready;

    always #5 clk = ~clk;

    dpb_master_rd #(.UDP_FRAME_MAX_SIZE_128(7'd91), .RD_LATENCY(LAT)) dut (
        .i_pclk(clk), .i_rst(rst), .i_rd_req(req), .i_rd_buf_rank(rank_in),
        .o_rd_busy(busy), .o_rd_done(done), .o_rd_error(err),
        .o_dpb_rd_b_clk(b_clk), .o_dpb_rd_b_ce(b_ce), .o_dpb_rd_b_oce(b_oce),
        .o_dpb_rd_b_rst(b_rst), .o_dpb_rd_b_wr_en(b_wr),
        .o_dpb_rd_b_addr(addr), .i_dpb_rd_b_rd_data(rd_data),
        .o_hdr_valid(hvld), .o_hdr_last(hlast), .o_hdr_udp_rank(hrank),
        .o_hdr_word_cnt(hcnt), .o_hdr_byte_cnt(hbcnt), .o_pkt_len(plen),
        .o_byte_data(bdata), .o_byte_valid(bvalid), .i_byte_ready(ready),
        .o_byte_sof(bsof), .o_byte_last(blast)
    );

    logic [127:0] mem [0:2047];
    logic [127:0] pipe [0:LAT-1];
    assign rd_data = pipe[LAT-1];

    always @(posedge clk) begin
        pipe[0] <= mem[addr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    int    n_chk = 0;
    int    n_fail = 0;
    byte_t exp_bytes[$];
    hdr_t  exp_hdr[$];
    bit    in_rst = 1'b1;
    bit    rnd_ready = 1'b0;
    logic [3:0]  exp_rank = '0;
    logic [10:0] max_addr = '0;
    int    n_badrank = 0;
    int    n_hs = 0, n_done = 0, n_err = 0, n_hvld = 0;
    int    cyc_g = 0, sof_cyc = 0, last_cyc = 0;
    bit    pend_done = 1'b0, prev_stall = 1'b0;
    logic [7:0] pd;
    logic  ps, pl;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [3:0] r, input int w,
                                       input int j);
        return 8'(w * 16 + j) ^ {r, r};
    endfunction

    function automatic logic [127:0] mkword(input logic [3:0] r, input int w);
        logic [127:0] v;
        v = '0;
        for (int j = 0; j < 16; j++) v[127-8*j -: 8] = pat(r, w, j);
        return v;
    endfunction

    initial begin
        ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        byte_t e;
        hdr_t  h;
        cyc_g++;
        if (in_rst) begin
            prev_stall = 1'b0;
            pend_done  = 1'b0;
        end else begin
            if (pend_done) begin
                chk("done_after_last", done, 1);
                chk("busy_fall_at_done", busy, 0);
                pend_done = 1'b0;
            end else begin
                chk("no_spurious_done", done, 0);
            end
            if (done) n_done++;
            if (err) n_err++;
            if (hvld) begin
                n_hvld++;
                if (exp_hdr.size() == 0) begin
                    chk("hdr_unexpected", hvld, 0);
                end else begin
                    h = exp_hdr.pop_front();
                    chk("hdr_last", hlast, h.lst);
                    chk("hdr_udp_rank", hrank, h.ur);
                    chk("hdr_word_cnt", hcnt, h.cnt);
                    chk("hdr_byte_cnt", hbcnt, h.bcnt);
                    chk("pkt_len", plen, h.len);
                end
            end
            if (prev_stall) begin
                chk("stall_valid", bvalid, 1);
                chk("stall_data", bdata, pd);
                chk("stall_sof", bsof, ps);
                chk("stall_last", blast, pl);
            end
            if (bvalid && ready) begin
                if (exp_bytes.size() == 0) begin
                    chk("byte_unexpected", bvalid, 0);
                end else begin
                    e = exp_bytes.pop_front();
                    chk("byte_data", bdata, e.d);
                    chk("byte_sof", bsof, e.s);
                    chk("byte_last", blast, e.l);
                end
                n_hs++;
                if (bsof) sof_cyc = cyc_g;
                if (blast) begin
                    last_cyc  = cyc_g;
                    pend_done = 1'b1;
                end
            end
            prev_stall = bvalid && !ready;
            pd = bdata;
            ps = bsof;
            pl = blast;
            if (busy) begin
                if (addr > max_addr) max_addr = addr;
                if (addr[10:7] != exp_rank) n_badrank++;
            end
        end
    end

    task automatic prep(input logic [3:0] rk, input logic lst,
                        input logic [7:0] ur, input logic [6:0] cnt,
                        input logic [5:0] bcnt, input logic [127:0] extra,
                        output bit bad, output int len);
        logic [127:0] hdr;
        hdr_t  h;
        byte_t b;
        hdr = extra;
        hdr[127] = lst;
        hdr[119:112] = ur;
        hdr[110:104] = cnt;
        hdr[101:96] = bcnt;
        mem[{rk, 7'd0}] = hdr;
        for (int w = 1; w < 128; w++) mem[{rk, 7'(w)}] = mkword(rk, w);
        bad = (extra != '0) || (cnt == 0) || (cnt > 91) || (bcnt > 15);
        len = bad ? 0 : int'(cnt) * 16 - ((bcnt != 0) ? 16 - int'(bcnt) : 0);
        if (!bad) begin
            h.lst = lst; h.ur = ur; h.cnt = cnt; h.bcnt = bcnt;
            h.len = 11'(len);
            exp_hdr.push_back(h);
            for (int p = 0; p < len; p++) begin
                b.d = pat(rk, 1 + p / 16, p % 16);
                b.s = (p == 0);
                b.l = (p == len - 1);
                exp_bytes.push_back(b);
            end
        end
        exp_rank  = rk;
        max_addr  = '0;
        n_badrank = 0;
    endtask

    task automatic issue(input logic [3:0] rk);
        @(negedge clk);
        req = 1'b1;
        rank_in = rk;
        @(negedge clk);
        req = 1'b0;
        chk("busy_after_req", busy, 1);
    endtask

    task automatic wait_end(input int budget, input bit inj,
                            output int first_low);
        int  d0, e0;
        bit  ok;
        d0 = n_done;
        e0 = n_err;
        ok = 1'b0;
        first_low = -1;
        for (int c = 0; c < budget; c++) begin
            if (inj && c == 30) begin
                req = 1'b1;
                rank_in = ~exp_rank;
            end
            if (inj && c == 31) req = 1'b0;
            if (!busy && first_low < 0) first_low = c;
            if (n_done != d0 || n_err != e0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("end_within_budget", 32'(ok), 1);
    endtask

    task automatic run_good(input logic [3:0] rk, input logic lst,
                            input logic [7:0] ur, input logic [6:0] cnt,
                            input logic [5:0] bcnt, input bit rnd,
                            input bit inj);
        bit bad;
        int len, h0, d0, e0, v0, fl;
        rnd_ready = rnd;
        prep(rk, lst, ur, cnt, bcnt, '0, bad, len);
        h0 = n_hs; d0 = n_done; e0 = n_err; v0 = n_hvld;
        issue(rk);
        wait_end(len * 4 + 60, inj, fl);
        chk("done_count", n_done - d0, 1);
        chk("no_error", n_err - e0, 0);
        chk("hdr_valid_count", n_hvld - v0, 1);
        chk("byte_count", n_hs - h0, len);
        chk("bytes_left", exp_bytes.size(), 0);
        chk("max_addr", max_addr, {rk, cnt});
        chk("rank_stable", n_badrank, 0);
        if (!rnd) chk("contiguous", last_cyc - sof_cyc + 1, len);
    endtask

    task automatic run_bad(input logic [3:0] rk, input logic [6:0] cnt,
                           input logic [127:0] extra);
        bit bad;
        int len, h0, d0, e0, v0, fl;
        rnd_ready = 1'b0;
        prep(rk, 1'b0, 8'h5a, cnt, 6'd0, extra, bad, len);
        h0 = n_hs; d0 = n_done; e0 = n_err; v0 = n_hvld;
        issue(rk);
        wait_end(40, 1'b0, fl);
        chk("err_count", n_err - e0, 1);
        chk("err_no_hdr", n_hvld - v0, 0);
        chk("err_no_bytes", n_hs - h0, 0);
        chk("err_no_done", n_done - d0, 0);
        chk("err_busy_low_in_time", 32'(fl >= 0 && fl <= LAT + 3), 1);
        chk("err_max_addr", max_addr, {rk, 7'd0});
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int h0;
        bit bad;
        int len;
        rst = 1'b1;
        req = 1'b0;
        rank_in = '0;
        in_rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_hvld", hvld, 0);
        chk("rst_valid", bvalid, 0);
        chk("rst_sof_last", {bsof, blast}, 0);
        chk("rst_addr", addr, 0);
        chk("rst_hdr", {hlast, hrank, hcnt, hbcnt}, 0);
        chk("rst_len", plen, 0);
        chk("tie_ce_oce_wr", {b_ce, b_oce, b_wr}, 3'b110);
        rst = 1'b0;
        @(negedge clk);
        in_rst = 1'b0;

        run_good(4'd2, 1'b0, 8'h10, 7'd91, 6'd0, 1'b0, 1'b0);
        run_good(4'd15, 1'b1, 8'ha5, 7'd3, 6'd5, 1'b0, 1'b0);
        run_good(4'd2, 1'b0, 8'h10, 7'd91, 6'd0, 1'b1, 1'b0);

        run_bad(4'd7, 7'd0, '0);
        run_bad(4'd8, 7'd92, '0);
        run_bad(4'd9, 7'd4, 128'h1 << 111);

        rnd_ready = 1'b0;
        prep(4'd5, 1'b0, 8'h77, 7'd91, 6'd0, '0, bad, len);
        h0 = n_hs;
        issue(4'd5);
        for (int c = 0; c < 400 && (n_hs - h0) < 100; c++) @(negedge clk);
        chk("reached_100_bytes", 32'((n_hs - h0) >= 100), 1);
        in_rst = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", bvalid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_bytes.delete();
        exp_hdr.delete();
        @(negedge clk);
        in_rst = 1'b0;
        run_good(4'd6, 1'b0, 8'h33, 7'd1, 6'd0, 1'b0, 1'b0);

        run_good(4'd3, 1'b0, 8'h44, 7'd10, 6'd0, 1'b0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_good(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)), 7'($urandom_range(1, 24)),
                     6'($urandom_range(0, 15)), 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
